// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: data width, default reset PC, fetch FSM
// state encoding and a word-alignment helper.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Handshake bundle between the fetch stage and its neighbours:
//   redirect_valid/redirect_pc        : jump/branch target from execute
//   imem_req/imem_addr/imem_ack/rdata : word read port to instruction memory
//   inst_valid/inst_ready/encoding/pc : instruction stream to decode
// master = fetch unit side, slave = environment (memory, decode, execute).
interface fetch_unit_if;
    import riscv_pkg::*;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_encoding;
    logic [XLEN-1:0] inst_pc;

    modport master (
        input  redirect_valid, redirect_pc, imem_ack, imem_rdata, inst_ready,
        output imem_req, imem_addr, inst_valid, inst_encoding, inst_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_ack, imem_rdata, inst_ready,
        input  imem_req, imem_addr, inst_valid, inst_encoding, inst_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small circular queue of {instruction, pc} entries feeding decode.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset (clears storage too)
//   flush        : synchronous empty; dominates push and pop
//   push/push_data, pop : enqueue at tail / dequeue head
//   head_data    : entry at the head (stale contents when empty)
//   count        : number of valid entries, 0..DEPTH
module fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // Slot freed by a same-cycle pop may be refilled; DEPTH is a power of
    // two so the pointers wrap naturally.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding word read at a
// time to instruction memory, queues returned words with their PCs for
// decode, and flushes everything on a redirect from execute.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fetch_unit_if.master (redirect, imem req/ack, decode stream)
//
// fetch_state | meaning
// ------------+-----------------------------------------------------------
// IDLE        | no request outstanding; issue at fetch_pc when queue has room
// WAIT        | request outstanding, response will be queued
// DROP        | request outstanding but redirected; response is discarded
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] inflight_q, inflight_d;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            push;
    logic            pop;
    logic            has_space;
    logic [CNT_W-1:0] count;
    logic [2*XLEN-1:0] head_data;

    assign has_space = (count < CNT_W'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            inflight_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        inflight_d = inflight_q;
        req        = 1'b0;
        addr       = fetch_pc_q;
        case (state_q)
            IDLE: begin
                // Issuing only with room guarantees the push cannot overflow.
                req  = has_space && !bus.redirect_valid;
                addr = fetch_pc_q;
                if (req) begin
                    inflight_d = fetch_pc_q;
                    if (!bus.imem_ack) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                req  = 1'b1;
                addr = inflight_q;
                if (bus.imem_ack) begin
                    state_d = IDLE;
                end else if (bus.redirect_valid) begin
                    // The request cannot be withdrawn; swallow its response.
                    state_d = DROP;
                end
            end
            DROP: begin
                req  = 1'b1;
                addr = inflight_q;
                if (bus.imem_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        push = req && bus.imem_ack && !bus.redirect_valid && (state_q != DROP);

        fetch_pc_d = fetch_pc_q;
        if (bus.redirect_valid) begin
            fetch_pc_d = word_align(bus.redirect_pc);
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
    end

    assign pop = bus.inst_valid && bus.inst_ready;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect_valid),
        .push      (push),
        .push_data ({bus.imem_rdata, addr}),
        .pop       (pop),
        .head_data (head_data),
        .count     (count)
    );

    // Memory must never see a request while reset is held.
    assign bus.imem_req      = req && !rst;
    assign bus.imem_addr     = addr;
    assign bus.inst_valid    = (count != '0);
    assign bus.inst_encoding = head_data[2*XLEN-1:XLEN];
    assign bus.inst_pc       = head_data[XLEN-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level model: the
// expected decode stream is a queue of {word, pc}; memory returns a hash of
// the address so data/PC pairing is visible.
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // reference model state
    logic [63:0] mq[$];
    logic [31:0] m_fpc;
    logic [31:0] m_out_addr;
    bit          m_out;
    bit          m_stale;
    int          wait_cnt;
    int          ack_mode;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        m_fpc      = RPC;
        m_out_addr = RPC;
        m_out      = 0;
        m_stale    = 0;
        wait_cnt   = 0;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit rv, input logic [31:0] rt, input bit rdy);
        logic        ack;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [63:0] head;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rt;
        bus.inst_ready     = rdy;
        #1;
        case (ack_mode)
            0:       ack = 1'b1;
            1:       ack = 1'($urandom_range(0, 1));
            default: ack = (wait_cnt >= 3);
        endcase
        bus.imem_ack   = ack;
        bus.imem_rdata = bus.imem_req ? mem_word(bus.imem_addr) : $urandom();
        #1;
        exp_req  = m_out || ((mq.size() < DEPTH) && !rv);
        exp_addr = m_out ? m_out_addr : m_fpc;
        chk("imem_req", bus.imem_req, exp_req);
        if (exp_req) chk("imem_addr", bus.imem_addr, exp_addr);
        chk("inst_valid", bus.inst_valid, (mq.size() != 0));
        if (mq.size() != 0) begin
            head = mq[0];
            chk("inst_pc", bus.inst_pc, head[31:0]);
            chk("inst_encoding", bus.inst_encoding, head[63:32]);
        end

        if (rv) begin
            mq.delete();
            if (m_out && !ack) m_stale = 1;
            else begin
                m_out   = 0;
                m_stale = 0;
            end
            m_fpc = {rt[31:2], 2'b00};
        end else begin
            if (mq.size() != 0 && rdy) void'(mq.pop_front());
            if (exp_req && ack) begin
                if (!m_stale) begin
                    mq.push_back({mem_word(exp_addr), exp_addr});
                    m_fpc = m_fpc + 32'd4;
                end
                m_out   = 0;
                m_stale = 0;
            end else if (exp_req && !m_out) begin
                m_out      = 1;
                m_out_addr = m_fpc;
            end
        end
        if (exp_req && !ack) wait_cnt++;
        else wait_cnt = 0;
        @(negedge clk);
    endtask

    // Called at a falling edge; reset asserted asynchronously while a
    // response is being offered, released at a later falling edge.
    task automatic do_reset();
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.inst_ready     = 1'b0;
        bus.imem_ack       = 1'b1;
        bus.imem_rdata     = 32'hDEAD_BEEF;
        #1;
        chk("rst_imem_req", bus.imem_req, 1'b0);
        chk("rst_imem_addr", bus.imem_addr, RPC);
        chk("rst_inst_valid", bus.inst_valid, 1'b0);
        chk("rst_inst_encoding", bus.inst_encoding, 32'h0);
        chk("rst_inst_pc", bus.inst_pc, 32'h0);
        repeat (2) @(negedge clk);
        chk("rst_hold_imem_req", bus.imem_req, 1'b0);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int guard;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_ack       = 1'b0;
        bus.imem_rdata     = '0;
        bus.inst_ready     = 1'b0;
        ack_mode           = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // zero-wait streaming
        ack_mode = 0;
        repeat (10) step(0, '0, 1);

        // decode stalled: queue fills, fetch stops, then drains in order
        repeat (6) step(0, '0, 0);
        repeat (6) step(0, '0, 1);

        // three-cycle memory latency
        ack_mode = 2;
        repeat (20) step(0, '0, 1);

        // redirect while a live request is waiting
        guard = 0;
        while (!(m_out && !m_stale && wait_cnt == 1) && guard < 10) begin
            step(0, '0, 1);
            guard++;
        end
        chk("reach_wait", 32'(m_out && !m_stale), 32'd1);
        step(1, 32'h0000_0100, 1);
        repeat (12) step(0, '0, 1);

        // redirect with a full queue while decode pops
        ack_mode = 0;
        repeat (4) step(0, '0, 0);
        step(1, 32'h0000_0040, 1);
        repeat (5) step(0, '0, 1);

        // PC wrap; low target bits ignored
        step(1, 32'hFFFF_FFFE, 1);
        repeat (5) step(0, '0, 1);

        // reset in the middle of a waiting request
        ack_mode = 2;
        step(1, 32'h0000_0200, 1);
        repeat (2) step(0, '0, 1);
        do_reset();
        ack_mode = 0;
        repeat (4) step(0, '0, 1);

        // random traffic
        for (int blk = 0; blk < 12; blk++) begin
            ack_mode = blk % 3;
            for (int i = 0; i < 200; i++) begin
                logic [31:0] tgt;
                case ($urandom_range(0, 3))
                    0:       tgt = 32'h0000_0100;
                    1:       tgt = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
                    default: tgt = $urandom();
                endcase
                step(($urandom_range(0, 99) < 8), tgt, ($urandom_range(0, 99) < 70));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
